// File: rtl/gcd_pkg.sv
// Shared definitions for the subtract/swap GCD datapath.
// Contents: default widths, the micro-op enum and the priority decode that
// turns the raw select/swap/subtract strobes into a single micro-op.
package gcd_pkg;

  localparam int unsigned GCD_WIDTH_DEF = 8;
  localparam int unsigned GCD_CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_SWAP = 2'd2,
    OP_SUB  = 2'd3
  } gcd_op_e;

  // select beats swap beats subtract; no strobe means hold
  function automatic gcd_op_e gcd_decode(input logic sel,
                                         input logic sw,
                                         input logic sub);
    gcd_op_e op;
    op = OP_HOLD;
    if (sel) begin
      op = OP_LOAD;
    end else if (sw) begin
      op = OP_SWAP;
    end else if (sub) begin
      op = OP_SUB;
    end
    return op;
  endfunction

endpackage : gcd_pkg

// File: rtl/gcd_opreg.sv
// Single operand register with write enable and asynchronous active-high reset.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-high; clears the register to zero
//   en_i   in   write enable
//   d_i    in   next value
//   q_o    out  current value
module gcd_opreg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule : gcd_opreg

// File: rtl/gcd_datapath.sv
// Operand datapath for the subtract/swap GCD engine.
// Holds X/Y, applies load/swap/subtract micro-ops from the control FSM, reports
// status, detects termination (X==0 after a full load), latches the GCD from Y,
// pulses done for one cycle and counts swap/subtract writes (saturating).
// Optional build macro: GCD_ERRCHK_EN adds a sticky protocol-error output err.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_x, in_y            operands captured on a select load
//   subtract, swap, select micro-op strobes (priority select > swap > subtract)
//   loadx, loady          per-register write enables
//   xgy, xg0              combinational status: X >= Y, X != 0
//   result, done          latched GCD and its one-cycle valid pulse
//   steps                 swap/subtract writes since last full load, saturating
//   err (GCD_ERRCHK_EN)   sticky: illegal strobe combo, underflowing subtract,
//                         or a register write while done is high
module gcd_datapath
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = GCD_WIDTH_DEF,
  parameter int unsigned CNT_W = GCD_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic             subtract,
  input  logic             swap,
  input  logic             select,
  input  logic             loadx,
  input  logic             loady,
  output logic             xgy,
  output logic             xg0,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic [CNT_W-1:0] steps
`ifdef GCD_ERRCHK_EN
  ,
  output logic             err
`endif
);

  gcd_op_e          op;
  logic [WIDTH-1:0] x_q, y_q, x_d, y_d;
  logic             x_en, y_en;
  logic             load_full, step_write, terminate;

  logic             armed_q, armed_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] steps_q, steps_d;

  assign op = gcd_decode(select, swap, subtract);

  // Next-value mux and write enables for X and Y; subtract never touches Y
  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    x_en = 1'b0;
    y_en = 1'b0;
    unique case (op)
      OP_LOAD: begin
        x_d  = in_x;
        y_d  = in_y;
        x_en = loadx;
        y_en = loady;
      end
      OP_SWAP: begin
        x_d  = y_q;
        y_d  = x_q;
        x_en = loadx;
        y_en = loady;
      end
      OP_SUB: begin
        x_d  = x_q - y_q;  // wraps on underflow
        x_en = loadx;
      end
      default: ;
    endcase
  end

  gcd_opreg #(.WIDTH(WIDTH)) u_xreg (
    .clk   (clk),
    .reset (reset),
    .en_i  (x_en),
    .d_i   (x_d),
    .q_o   (x_q)
  );

  gcd_opreg #(.WIDTH(WIDTH)) u_yreg (
    .clk   (clk),
    .reset (reset),
    .en_i  (y_en),
    .d_i   (y_d),
    .q_o   (y_q)
  );

  assign xgy = (x_q >= y_q);
  assign xg0 = (x_q != '0);

  assign load_full  = (op == OP_LOAD) && loadx && loady;
  assign step_write = ((op == OP_SWAP) || (op == OP_SUB)) && (x_en || y_en);
  // A load in the same cycle wins; termination is judged on the next clean cycle
  assign terminate  = armed_q && !xg0 && !select;

  // Arming, step counting and result capture
  always_comb begin
    armed_d  = armed_q;
    steps_d  = steps_q;
    result_d = result_q;
    done_d   = 1'b0;
    if (load_full) begin
      armed_d = 1'b1;
      steps_d = '0;
    end else begin
      if (step_write && (steps_q != '1)) begin
        steps_d = steps_q + CNT_W'(1);
      end
      if (terminate) begin
        result_d = y_q;
        done_d   = 1'b1;
        armed_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed_q  <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      steps_q  <= '0;
    end else begin
      armed_q  <= armed_d;
      done_q   <= done_d;
      result_q <= result_d;
      steps_q  <= steps_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign steps  = steps_q;

`ifdef GCD_ERRCHK_EN
  logic err_q, err_d, err_set;

  assign err_set = (swap && subtract && !select)
                 || ((op == OP_SUB) && (x_q < y_q))
                 || (done_q && (x_en || y_en));

  // Sticky flag; a full load starts a fresh computation and clears it
  always_comb begin
    err_d = err_q;
    if (load_full) begin
      err_d = 1'b0;
    end else if (err_set) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule : gcd_datapath

// File: tb/tb_gcd_datapath.sv
// Directed bench for gcd_datapath: a default-width instance plus a CNT_W=3
// instance sharing the same stimulus for the saturation case.
module tb_gcd_datapath;

  logic       clk;
  logic       reset;
  logic [7:0] in_x, in_y;
  logic       subtract, swap, select, loadx, loady;

  logic       xgy, xg0, done;
  logic [7:0] result, steps;
  logic       xgy3, xg03, done3;
  logic [7:0] result3;
  logic [2:0] steps3;
`ifdef GCD_ERRCHK_EN
  logic       err, err3;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  gcd_datapath dut (
    .clk      (clk),
    .reset    (reset),
    .in_x     (in_x),
    .in_y     (in_y),
    .subtract (subtract),
    .swap     (swap),
    .select   (select),
    .loadx    (loadx),
    .loady    (loady),
    .xgy      (xgy),
    .xg0      (xg0),
    .result   (result),
    .done     (done),
    .steps    (steps)
`ifdef GCD_ERRCHK_EN
    ,
    .err      (err)
`endif
  );

  gcd_datapath #(.CNT_W(3)) dut3 (
    .clk      (clk),
    .reset    (reset),
    .in_x     (in_x),
    .in_y     (in_y),
    .subtract (subtract),
    .swap     (swap),
    .select   (select),
    .loadx    (loadx),
    .loady    (loady),
    .xgy      (xgy3),
    .xg0      (xg03),
    .result   (result3),
    .done     (done3),
    .steps    (steps3)
`ifdef GCD_ERRCHK_EN
    ,
    .err      (err3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic sel, input logic sw, input logic sub,
                       input logic lx, input logic ly,
                       input logic [7:0] ix, input logic [7:0] iy);
    select   = sel;
    swap     = sw;
    subtract = sub;
    loadx    = lx;
    loady    = ly;
    in_x     = ix;
    in_y     = iy;
  endtask

  // Advance one edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 8'd0, 8'd0);
    #12;
    check("rst_result", 32'(result), 32'd0);
    check("rst_done",   32'(done),   32'd0);
    check("rst_steps",  32'(steps),  32'd0);
    check("rst_xgy",    32'(xgy),    32'd1);
    check("rst_xg0",    32'(xg0),    32'd0);
    @(negedge clk);
    reset = 1'b0;

    // 1: gcd(12,18) = 6 via swap,sub,swap,sub,sub
    drive(1, 0, 0, 1, 1, 8'd12, 8'd18); tick();
    check("t1_load_xgy", 32'(xgy), 32'd0);
    check("t1_load_xg0", 32'(xg0), 32'd1);
    drive(0, 1, 0, 1, 1, 8'd0, 8'd0); tick();   // X=18 Y=12
    check("t1_swap_xgy", 32'(xgy), 32'd1);
    drive(0, 0, 1, 1, 1, 8'd0, 8'd0); tick();   // X=6
    drive(0, 1, 0, 1, 1, 8'd0, 8'd0); tick();   // X=12 Y=6
    drive(0, 0, 1, 1, 1, 8'd0, 8'd0); tick();   // X=6
    drive(0, 0, 1, 1, 1, 8'd0, 8'd0); tick();   // X=0
    check("t1_x0_xg0",   32'(xg0),   32'd0);
    check("t1_x0_done",  32'(done),  32'd0);
    check("t1_steps",    32'(steps), 32'd5);
    drive(0, 0, 0, 0, 0, 8'd0, 8'd0); tick();
    check("t1_done",     32'(done),   32'd1);
    check("t1_result",   32'(result), 32'd6);
    tick();
    check("t1_done_off", 32'(done),   32'd0);
    check("t1_result_h", 32'(result), 32'd6);
    tick();
    check("t1_no_refire", 32'(done), 32'd0);

    // 2: Y=0 never terminates; subtract leaves X unchanged
    drive(1, 0, 0, 1, 1, 8'd35, 8'd0); tick();
    check("t2_xg0", 32'(xg0), 32'd1);
    check("t2_xgy", 32'(xgy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 1, 1, 8'd0, 8'd0); tick();
      check("t2_x",    32'(dut.x_q), 32'd35);
      check("t2_done", 32'(done),    32'd0);
    end
    check("t2_steps", 32'(steps), 32'd3);
    drive(0, 0, 0, 0, 0, 8'd0, 8'd0); tick();
    check("t2_idle_done", 32'(done), 32'd0);

    // 3: X=0 at load terminates immediately with result=Y
    drive(1, 0, 0, 1, 1, 8'd0, 8'd9); tick();
    check("t3_load_done", 32'(done), 32'd0);
    drive(0, 0, 0, 0, 0, 8'd0, 8'd0); tick();
    check("t3_done",   32'(done),   32'd1);
    check("t3_result", 32'(result), 32'd9);
    check("t3_steps",  32'(steps),  32'd0);
    tick();
    check("t3_done_off", 32'(done), 32'd0);

    // 4: step counter saturation on the CNT_W=3 instance
    drive(1, 0, 0, 1, 1, 8'd1, 8'd2); tick();
    check("t4_steps3_load", 32'(steps3), 32'd0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 0, 1, 1, 8'd0, 8'd0); tick();
      if (i == 6) check("t4_steps3_at7", 32'(steps3), 32'd7);
    end
    check("t4_steps3_sat", 32'(steps3), 32'd7);
    check("t4_steps8",     32'(steps),  32'd10);
    drive(0, 1, 0, 1, 0, 8'd0, 8'd0); tick();   // swap with loadx only
    check("t4_swapx_only_x", 32'(dut.x_q), 32'd2);
    check("t4_swapx_only_y", 32'(dut.y_q), 32'd2);

    // 5: reset with a done pending clears everything at once
    drive(1, 0, 0, 1, 1, 8'd6, 8'd12); tick();
    drive(0, 1, 0, 1, 1, 8'd0, 8'd0); tick();   // X=12 Y=6
    drive(0, 0, 1, 1, 1, 8'd0, 8'd0); tick();   // X=6
    drive(0, 0, 1, 1, 1, 8'd0, 8'd0); tick();   // X=0, done due next edge
    check("t5_pre_steps", 32'(steps), 32'd3);
    drive(0, 0, 0, 0, 0, 8'd0, 8'd0);
    #2;
    reset = 1'b1;
    #1;
    check("t5_x",      32'(dut.x_q), 32'd0);
    check("t5_y",      32'(dut.y_q), 32'd0);
    check("t5_result", 32'(result),  32'd0);
    check("t5_steps",  32'(steps),   32'd0);
    check("t5_done",   32'(done),    32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("t5_done_lost", 32'(done),   32'd0);
    check("t5_result_z",  32'(result), 32'd0);

`ifdef GCD_ERRCHK_EN
    // 6: underflowing subtract wraps and flags err; full load clears it
    drive(1, 0, 0, 1, 1, 8'd3, 8'd5); tick();
    check("t6_err_clear", 32'(err), 32'd0);
    drive(0, 0, 1, 1, 1, 8'd0, 8'd0); tick();
    check("t6_wrap", 32'(dut.x_q), 32'd254);
    check("t6_err",  32'(err),     32'd1);
    drive(0, 0, 0, 0, 0, 8'd0, 8'd0); tick();
    check("t6_err_sticky", 32'(err), 32'd1);
    drive(1, 0, 0, 1, 1, 8'd3, 8'd5); tick();
    check("t6_err_reload", 32'(err), 32'd0);
`else
    // Wrap-around of subtract is identical without the error checker
    drive(1, 0, 0, 1, 1, 8'd3, 8'd5); tick();
    drive(0, 0, 1, 1, 1, 8'd0, 8'd0); tick();
    check("t6_wrap", 32'(dut.x_q), 32'd254);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_gcd_datapath
